// File: rtl/sub_seq_pkg.sv
// Shared constants for the byte-serial wide subtractor sequencer.
package sub_seq_pkg;
    localparam int BYTE_W         = 8;
    localparam int NBYTES_DEFAULT = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/full_sub_8bit.sv
// Purely combinational 8-bit ripple subtractor: diff = a - b - bin, bout = borrow out.
module full_sub_8bit
    import sub_seq_pkg::*;
(
    input  logic [BYTE_W-1:0] a_i,
    input  logic [BYTE_W-1:0] b_i,
    input  logic              bin_i,
    output logic [BYTE_W-1:0] diff_o,
    output logic              bout_o
);
    logic [BYTE_W:0]   brw;
    logic [BYTE_W-1:0] d;

    always_comb begin
        brw    = '0;
        d      = '0;
        brw[0] = bin_i;
        for (int i = 0; i < BYTE_W; i++) begin
            d[i]     = a_i[i] ^ b_i[i] ^ brw[i];
            brw[i+1] = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & brw[i]);
        end
    end

    assign diff_o = d;
    assign bout_o = brw[BYTE_W];
endmodule

// File: rtl/sub_seq_ctrl.sv
// Wide a - b - bin computed one byte per clock, LSB first, on one shared 8-bit subtractor.
// Start accepted in IDLE/DONE gives done NBYTES+1 cycles later; start while busy is ignored.
module sub_seq_ctrl
    import sub_seq_pkg::*;
#(
    parameter  int NBYTES = NBYTES_DEFAULT,
    localparam int OP_W   = BYTE_W * NBYTES
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [OP_W-1:0] a,
    input  logic [OP_W-1:0] b,
    input  logic            bin,
    output logic            busy,
    output logic            done,
    output logic [OP_W-1:0] diff,
    output logic            bout,
    output logic            zero
);
    localparam int              CNT_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBYTES - 1);

    logic [1:0]        state_q, state_d;
    logic [OP_W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
    logic [OP_W-1:0]   diff_q, diff_d;
    logic              brw_q, brw_d;
    logic              bout_q, bout_d, zero_q, zero_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [BYTE_W-1:0] sub_diff;
    logic              sub_bout;
    logic [OP_W-1:0]   top_byte, res_shift;

    full_sub_8bit u_sub (
        .a_i    (a_q[BYTE_W-1:0]),
        .b_i    (b_q[BYTE_W-1:0]),
        .bin_i  (brw_q),
        .diff_o (sub_diff),
        .bout_o (sub_bout)
    );

    always_comb begin
        // Result fills from the top so after NBYTES shifts byte 0 lands at the bottom.
        top_byte                   = '0;
        top_byte[OP_W-1 -: BYTE_W] = sub_diff;
        res_shift                  = (res_q >> BYTE_W) | top_byte;

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        brw_d   = brw_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        zero_d  = zero_q;

        case (state_q)
            ST_RUN: begin
                a_d   = a_q >> BYTE_W;
                b_d   = b_q >> BYTE_W;
                res_d = res_shift;
                brw_d = sub_bout;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    diff_d  = res_shift;
                    bout_d  = sub_bout;
                    zero_d  = (res_shift == '0);
                end
            end
            default: begin
                if (start) begin
                    state_d = ST_RUN;
                    a_d     = a;
                    b_d     = b;
                    brw_d   = bin;
                    res_d   = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            brw_q   <= brw_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            zero_q  <= zero_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign diff = diff_q;
    assign bout = bout_q;
    assign zero = zero_q;
endmodule

// File: tb/tb_sub_seq_ctrl.sv
// Self-checking bench for sub_seq_ctrl (NBYTES=4 main instance, NBYTES=1 corner instance).
module tb_sub_seq_ctrl;
    localparam int NB = 4;

    logic        clk, rst;
    logic        in_start, in_bin;
    logic [31:0] in_a, in_b;
    logic        busy, done, bout, zero;
    logic [31:0] diff;

    logic        start1, bin1, busy1, done1, bout1, zero1;
    logic [7:0]  a1, b1, diff1;

    int checks = 0;
    int errors = 0;

    logic [31:0] hold_diff;
    logic        hold_bout, hold_zero;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        bin;
        logic [31:0] d;
        logic        bo;
        logic        z;
    } vec_t;
    vec_t vt[8];

    sub_seq_ctrl #(.NBYTES(NB)) dut (
        .clk(clk), .rst(rst), .start(in_start), .a(in_a), .b(in_b), .bin(in_bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout), .zero(zero)
    );

    sub_seq_ctrl #(.NBYTES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1), .zero(zero1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: full-precision integer arithmetic, returns {bout, zero, diff}.
    function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y, input logic c);
        logic [63:0] full;
        logic        bo;
        full = 64'(x) - 64'(y) - 64'(c);
        bo   = (64'(x) < (64'(y) + 64'(c)));
        return {bo, (full[31:0] == 32'd0), full[31:0]};
    endfunction

    task automatic run_op(input string nm, input logic [31:0] ta, input logic [31:0] tb_,
                          input logic tbin, input logic [31:0] ed, input logic eb, input logic ez);
        in_a = ta; in_b = tb_; in_bin = tbin; in_start = 1'b1;
        cyc;
        in_start = 1'b0;
        for (int k = 1; k <= NB; k++) begin
            check({nm, " busy/done in run"}, {62'd0, busy, done}, 64'd2);
            check({nm, " diff held in run"}, 64'(diff), 64'(hold_diff));
            cyc;
        end
        check({nm, " done pulse"}, {62'd0, busy, done}, 64'd1);
        check({nm, " diff"}, 64'(diff), 64'(ed));
        check({nm, " bout/zero"}, {62'd0, bout, zero}, {62'd0, eb, ez});
        hold_diff = ed; hold_bout = eb; hold_zero = ez;
        cyc;
        check({nm, " done one cycle"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic [33:0] m;
        logic [31:0] ra, rb;
        logic        rbin;
        logic [15:0] f1;

        vt[0] = '{32'h12345678, 32'h00000001, 1'b0, 32'h12345677, 1'b0, 1'b0};
        vt[1] = '{32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
        vt[2] = '{32'h00000100, 32'h00000100, 1'b0, 32'h00000000, 1'b0, 1'b1};
        vt[3] = '{32'h00000005, 32'h00000004, 1'b1, 32'h00000000, 1'b0, 1'b1};
        vt[4] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
        vt[5] = '{32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
        vt[6] = '{32'h00000000, 32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b1, 1'b1};
        vt[7] = '{32'h80000000, 32'h7FFFFFFF, 1'b0, 32'h00000001, 1'b0, 1'b0};

        rst = 1'b1; in_start = 1'b0; in_a = '0; in_b = '0; in_bin = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
        hold_diff = '0; hold_bout = 1'b0; hold_zero = 1'b0;
        repeat (3) cyc;
        rst = 1'b0;
        cyc;
        check("reset busy/done", {62'd0, busy, done}, 64'd0);
        check("reset diff", 64'(diff), 64'd0);
        check("reset bout/zero", {62'd0, bout, zero}, 64'd0);
        check("reset nb1 outputs", {53'd0, busy1, done1, bout1, zero1, diff1}, 64'd0);

        for (int i = 0; i < 8; i++)
            run_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].bin, vt[i].d, vt[i].bo, vt[i].z);

        // start during RUN must not disturb the latched operands
        in_a = 32'h10; in_b = 32'h01; in_bin = 1'b0; in_start = 1'b1;
        cyc;
        in_a = 32'hFF; in_b = 32'hFF;
        cyc; cyc;
        in_start = 1'b0;
        cyc;
        check("ignore start still busy", {62'd0, busy, done}, 64'd2);
        cyc;
        check("ignore start done", {62'd0, busy, done}, 64'd1);
        check("ignore start diff", 64'(diff), 64'h0F);
        for (int k = 0; k < 10; k++) begin
            cyc;
            check("idle hold", {29'd0, busy, done, bout, zero, diff}, {35'd0, 32'h0F} >> 3 << 3 | 64'h0F);
        end

        // reset in the second RUN cycle
        in_a = 32'h12345678; in_b = 32'h1; in_start = 1'b1;
        cyc;
        in_start = 1'b0;
        cyc;
        check("pre-reset busy", 64'(busy), 64'd1);
        rst = 1'b1;
        cyc;
        rst = 1'b0;
        check("abort outputs", {29'd0, busy, done, bout, zero, diff}, 64'd0);
        for (int k = 0; k < NB + 2; k++) begin
            cyc;
            check("no done after abort", {62'd0, busy, done}, 64'd0);
        end
        hold_diff = '0; hold_bout = 1'b0; hold_zero = 1'b0;
        run_op("after abort", 32'h12345678, 32'h1, 1'b0, 32'h12345677, 1'b0, 1'b0);

        // start held high: back-to-back ops, one result per NB+1 cycles
        begin
            logic [31:0] oa[3], ob[3], od[3];
            logic        obo[3], oz[3];
            oa = '{32'd3, 32'd1, 32'd7};  ob = '{32'd1, 32'd3, 32'd7};
            od = '{32'h2, 32'hFFFFFFFE, 32'h0};
            obo = '{1'b0, 1'b1, 1'b0};    oz = '{1'b0, 1'b0, 1'b1};
            in_a = oa[0]; in_b = ob[0]; in_bin = 1'b0; in_start = 1'b1;
            cyc;
            for (int i = 0; i < 3; i++) begin
                if (i < 2) begin
                    in_a = oa[i+1]; in_b = ob[i+1];
                end else begin
                    in_start = 1'b0;
                end
                for (int k = 1; k <= NB; k++) begin
                    check($sformatf("b2b op%0d no early done", i), 64'(done), 64'd0);
                    cyc;
                end
                check($sformatf("b2b op%0d done", i), 64'(done), 64'd1);
                check($sformatf("b2b op%0d result", i), {bout, zero, diff}, {30'd0, obo[i], oz[i], od[i]});
                if (i < 2) cyc;
            end
            hold_diff = od[2]; hold_bout = obo[2]; hold_zero = oz[2];
            cyc;
        end

        // randomized against the reference model
        for (int n = 0; n < 150; n++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = ra + 32'd1;
                2: rb = ra & 32'hFFFF00FF;
                default: rb = $urandom;
            endcase
            rbin = 1'($urandom_range(0, 1));
            m = model(ra, rb, rbin);
            run_op($sformatf("rand%0d", n), ra, rb, rbin, m[31:0], m[33], m[32]);
            repeat ($urandom_range(0, 2)) cyc;
        end

        // single-byte instance: latency 2
        for (int n = 0; n < 20; n++) begin
            a1 = 8'($urandom); b1 = (n % 4 == 0) ? a1 : 8'($urandom); bin1 = 1'($urandom_range(0, 1));
            f1 = 16'(a1) - 16'(b1) - 16'(bin1);
            start1 = 1'b1;
            cyc;
            start1 = 1'b0;
            check("nb1 run", {62'd0, busy1, done1}, 64'd2);
            cyc;
            check("nb1 done", {62'd0, busy1, done1}, 64'd1);
            check("nb1 result", {54'd0, bout1, zero1, diff1},
                  {54'd0, (16'(a1) < 16'(b1) + 16'(bin1)), (f1[7:0] == 8'd0), f1[7:0]});
            cyc;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
